// File: rtl/odd_change_checker.sv
// ---------------------------------------------------------------------------
// odd_change_checker
//
// Watches a single-bit stream that should start at 0 and then toggle on every
// enabled clock. After LOCK_LEN consecutive toggles the checker declares lock.
// While locked it counts correct toggles (good_cnt) and missed toggles
// (bad_cnt), and reports each missed toggle with a one-cycle err_pulse and a
// sticky err_sticky flag.
//
// State table
//   state  | meaning
//   IDLE   | waiting for an enabled sample with din=0 to start a run
//   SYNC   | counting consecutive toggles toward LOCK_LEN
//   LOCKED | stream toggling as expected; good/bad toggles are counted
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   sample enable; en=0 drops the FSM back to IDLE
//   din        in   monitored stream
//   clr        in   synchronous clear of counters and err_sticky
//   locked     out  1 while the FSM sits in LOCKED
//   err_pulse  out  one-cycle pulse per missed toggle while locked
//   err_sticky out  set by err_pulse, held until clr or reset
//   good_cnt   out  saturating count of correct toggles while locked
//   bad_cnt    out  saturating count of missed toggles while locked
// ---------------------------------------------------------------------------
module odd_change_checker #(
  parameter int CNT_W    = 16,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Run length compared on 9 bits so run+1 never overflows before the compare.
  localparam logic [8:0] LOCK_LEN_C = 9'(LOCK_LEN);

  state_e           state_q, state_d;
  logic             prev_q, prev_d;
  logic [7:0]       run_q, run_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  logic       toggle;
  logic [8:0] run_inc;
  logic       good_evt;
  logic       bad_evt;

  assign toggle  = (din != prev_q);
  assign run_inc = {1'b0, run_q} + 9'd1;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_q       <= 1'b0;
      run_q        <= 8'd0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      good_q       <= '0;
      bad_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: FSM transitions, prev/run tracking, event flags
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_d    = run_q;
    good_evt = 1'b0;
    bad_evt  = 1'b0;

    if (!en) begin
      // Any disabled edge abandons the current run; prev is kept.
      state_d = ST_IDLE;
      run_d   = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!din) begin
            state_d = ST_SYNC;
            prev_d  = 1'b0;
            run_d   = 8'd0;
          end
        end

        ST_SYNC: begin
          if (toggle) begin
            prev_d = din;
            run_d  = run_inc[7:0];
            if (run_inc == LOCK_LEN_C) begin
              state_d = ST_LOCKED;
            end
          end else begin
            // A repeat before lock only restarts the run; it is not an error.
            run_d = 8'd0;
          end
        end

        ST_LOCKED: begin
          if (toggle) begin
            prev_d   = din;
            good_evt = 1'b1;
          end else begin
            bad_evt = 1'b1;
            state_d = ST_SYNC;
            run_d   = 8'd0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          run_d   = 8'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output-side next values: error flags and saturating counters.
  // clr wins over a same-edge increment or sticky set, but not over err_pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    err_pulse_d  = bad_evt;
    err_sticky_d = err_sticky_q;
    good_d       = good_q;
    bad_d        = bad_q;

    if (clr) begin
      err_sticky_d = 1'b0;
      good_d       = '0;
      bad_d        = '0;
    end else begin
      if (bad_evt) begin
        err_sticky_d = 1'b1;
      end
      if (good_evt && !(&good_q)) begin
        good_d = good_q + CNT_W'(1);
      end
      if (bad_evt && !(&bad_q)) begin
        bad_d = bad_q + CNT_W'(1);
      end
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign good_cnt   = good_q;
  assign bad_cnt    = bad_q;

endmodule

// File: tb/tb_odd_change_checker.sv
module tb_odd_change_checker;

  localparam int CNT_W    = 4;
  localparam int LOCK_LEN = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             din;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  int n_checks;
  int n_fail;

  odd_change_checker #(
    .CNT_W    (CNT_W),
    .LOCK_LEN (LOCK_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .clr        (clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       din;
    logic       clr;
    logic       l;
    logic       ep;
    logic       es;
    logic [3:0] g;
    logic [3:0] b;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic d, input logic c,
                     input logic l, input logic ep, input logic es,
                     input int g, input int b);
    vec_t v;
    v.en = e; v.din = d; v.clr = c;
    v.l = l; v.ep = ep; v.es = es;
    v.g = 4'(g); v.b = 4'(b);
    vecs.push_back(v);
  endtask

  // Packed as {locked, err_pulse, err_sticky, good_cnt, bad_cnt}
  task automatic check(input string name, input logic l, input logic ep,
                       input logic es, input logic [3:0] g, input logic [3:0] b);
    logic [10:0] act;
    logic [10:0] exp;
    act = {locked, err_pulse, err_sticky, good_cnt, bad_cnt};
    exp = {l, ep, es, g, b};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got l=%b ep=%b es=%b g=%0d b=%0d, want l=%b ep=%b es=%b g=%0d b=%0d",
               name, act[10], act[9], act[8], act[7:4], act[3:0],
               l, ep, es, g, b);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic c);
    en = e; din = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, want finish before 20000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Held at 1 from reset: never leaves IDLE
    for (int i = 0; i < 20; i++) add(1, 1, 0, 0, 0, 0, 0, 0);
    // Lock acquisition: 0 starts, four toggles lock
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    // One good toggle, then a miss, then relock
    add(1, 1, 0, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 1, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1);
    add(1, 1, 0, 1, 0, 1, 1, 1);
    // 20 good toggles: good_cnt saturates at 15
    for (int k = 1; k <= 20; k++)
      add(1, (k % 2 == 0) ? 1'b1 : 1'b0, 0, 1, 0, 1, (1 + k > 15) ? 15 : 1 + k, 1);
    // Miss with clr on the same edge
    add(1, 1, 1, 0, 1, 0, 0, 0);
    // en=0 drops to IDLE; din=1 stays IDLE; restart and relock
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 1, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1);
    // clr while in SYNC with a repeat: no error, counters cleared
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1, 0);
    // en=0 while locked: counters held
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 1, 0);
    // clr overrides a same-edge good increment
    add(1, 1, 1, 1, 0, 0, 0, 0);

    en = 1'b0; din = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_state", 0, 0, 0, 4'd0, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].din, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].l, vecs[i].ep, vecs[i].es,
            vecs[i].g, vecs[i].b);
    end

    // Locked with prev=1: seven good toggles bring good_cnt to 7
    for (int k = 1; k <= 7; k++) step(1, (k % 2 == 0) ? 1'b1 : 1'b0, 0);
    check("pre_async_reset", 1, 0, 0, 4'd7, 4'd0);

    // Async reset mid-cycle: outputs clear before the next edge
    #3 rst_n = 1'b0;
    #1 check("async_reset", 0, 0, 0, 4'd0, 4'd0);
    step(1, 0, 0);
    check("held_in_reset", 0, 0, 0, 4'd0, 4'd0);
    rst_n = 1'b1;

    // After release the block restarts from IDLE and needs a full relock
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    check("relock_not_yet", 0, 0, 0, 4'd0, 4'd0);
    step(1, 0, 0);
    check("relock_done", 1, 0, 0, 4'd0, 4'd0);
    step(1, 0, 0);
    check("miss_pulse", 0, 1, 1, 4'd0, 4'd1);
    step(1, 1, 0);
    check("pulse_one_cycle", 0, 0, 1, 4'd0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
